// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes and FSM state encoding shared by the sequential ALU
package alu_pkg;

  localparam logic [2:0] OP_SUM  = 3'b000;
  localparam logic [2:0] OP_RES  = 3'b001;
  localparam logic [2:0] OP_PROD = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_MOD  = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_divmod.sv
// rtl/alu_seq_divmod.sv - iterative restoring divider, one quotient bit per clock
// done is asserted during the final iteration with the final quotient/remainder on the outputs.
module alu_seq_divmod
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic             busy;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] den;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] q_next;

  // q starts as the dividend and fills with quotient bits from the right as dividend bits leave
  always_comb begin
    shifted  = {rem, q[WIDTH-1]};
    trial    = shifted - {1'b0, den};
    fits     = shifted >= {1'b0, den};
    rem_next = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    q_next   = {q[WIDTH-2:0], fits};
  end

  assign done      = busy && (cnt == CNT_W'(WIDTH - 1));
  assign quotient  = q_next;
  assign remainder = rem_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      q    <= '0;
      rem  <= '0;
      den  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      q    <= dividend;
      rem  <= '0;
      den  <= divisor;
    end else if (busy) begin
      q   <= q_next;
      rem <= rem_next;
      cnt <= cnt + CNT_W'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle unsigned ALU with valid/ready handshake and status flags
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       ctrl_i,
  input  logic [WIDTH-1:0] data0_i,
  input  logic [WIDTH-1:0] data1_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             ovf_o,
  output logic             zero_o,
  output logic             div0_o,
  output logic             err_o
);

  localparam int PW = 2 * WIDTH;

  state_t           state, state_next;
  logic [2:0]       op;
  logic [WIDTH-1:0] a, b;
  logic [CNT_W-1:0] cnt;
  logic [PW-1:0]    acc, acc_next, partial;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] res_c, quot, rem;
  logic             carry_c, ovf_c, div0_c, err_c;
  logic             div_start, div_done, last_bit;

  assign ready_o   = (state == IDLE);
  assign valid_o   = (state == DONE);
  assign last_bit  = (cnt == CNT_W'(WIDTH - 1));
  assign div_start = ready_o && valid_i && (ctrl_i == OP_DIV || ctrl_i == OP_MOD)
                     && (data1_i != '0);

  alu_seq_divmod #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_divmod (
    .clk       (clk_i),
    .rst       (rst_i),
    .start     (div_start),
    .dividend  (data0_i),
    .divisor   (data1_i),
    .done      (div_done),
    .quotient  (quot),
    .remainder (rem)
  );

  always_comb begin
    sum      = {1'b0, a} + {1'b0, b};
    diff     = {1'b0, a} - {1'b0, b};
    partial  = b[cnt] ? (PW'(a) << cnt) : '0;
    acc_next = acc + partial;
    res_c    = '0;
    carry_c  = 1'b0;
    ovf_c    = 1'b0;
    div0_c   = 1'b0;
    err_c    = 1'b0;
    case (op)
      OP_SUM:  begin res_c = sum[WIDTH-1:0];  carry_c = sum[WIDTH];  end
      OP_RES:  begin res_c = diff[WIDTH-1:0]; carry_c = diff[WIDTH]; end
      OP_PROD: begin res_c = acc_next[WIDTH-1:0]; ovf_c = |acc_next[PW-1:WIDTH]; end
      OP_DIV:  begin
        div0_c = (b == '0);
        res_c  = div0_c ? '1 : quot;
      end
      OP_MOD:  begin
        div0_c = (b == '0);
        res_c  = div0_c ? a : rem;
      end
      default: err_c = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (valid_i) state_next = EXEC;
      EXEC: begin
        case (op)
          OP_PROD:        if (last_bit) state_next = DONE;
          OP_DIV, OP_MOD: if (b == '0 || div_done) state_next = DONE;
          default:        state_next = DONE;
        endcase
      end
      DONE: if (ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Result and flags are only written on entry to DONE and cleared on leaving it
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op       <= '0;
      a        <= '0;
      b        <= '0;
      cnt      <= '0;
      acc      <= '0;
      result_o <= '0;
      carry_o  <= 1'b0;
      ovf_o    <= 1'b0;
      zero_o   <= 1'b0;
      div0_o   <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (valid_i) begin
          op  <= ctrl_i;
          a   <= data0_i;
          b   <= data1_i;
          cnt <= '0;
          acc <= '0;
        end
        EXEC: begin
          cnt <= cnt + CNT_W'(1);
          acc <= acc_next;
          if (state_next == DONE) begin
            result_o <= res_c;
            carry_o  <= carry_c;
            ovf_o    <= ovf_c;
            zero_o   <= (res_c == '0);
            div0_o   <= div0_c;
            err_o    <= err_c;
          end
        end
        DONE: if (ready_i) begin
          result_o <= '0;
          carry_o  <= 1'b0;
          ovf_o    <= 1'b0;
          zero_o   <= 1'b0;
          div0_o   <= 1'b0;
          err_o    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
